miller_eof_detector: RTL and testbench

- Parametrised end-of-frame detector for the modified-Miller (ISO 14443-A, 106 kb/s) reader-to-card receive path.
- Sits after the SoF detector and next to the Miller decoder.
- Declares EoF after a configurable run of pause-free carrier, counts the ETUs in the frame, and re-arms on every new SoF, so it handles back-to-back frames without a reset.

---
 rtl/miller_eof_detector.sv | 127 ++++++++++++
 tb/tb_miller_eof_detector.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/miller_eof_detector.sv
// End-of-frame detector for the modified-Miller 106 kb/s reader-to-card path.
// Optional frame-length timeout is built when EOF_TIMEOUT_EN is defined.
module miller_eof_detector #(
  parameter int unsigned CLK_PER_ETU = 8,
  parameter int unsigned IDLE_ETU    = 2,
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned MAX_ETU     = 512
) (
  input  logic             in_clk,
  input  logic             in_PoR,
  input  logic             in_enable,
  input  logic             in_sof,
  input  logic             in_data,
  input  logic             in_etu_strobe,
  output logic             out_eof,
  output logic             out_frame_active,
  output logic [CNT_W-1:0] out_etu_count,
  output logic             out_overflow,
  output logic             out_timeout
);

  localparam int unsigned IDLE_CLKS = CLK_PER_ETU * IDLE_ETU;
  localparam int unsigned IDLE_W    = $clog2(IDLE_CLKS + 1);
  localparam logic [IDLE_W-1:0] IdleLast = IDLE_W'(IDLE_CLKS - 1);
  localparam logic [CNT_W-1:0]  CntMax   = '1;

  typedef enum logic [1:0] {StIdle, StActive, StEof} state_e;

  state_e             state_q, state_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]   etu_cnt_q, etu_cnt_d;
  logic               overflow_q, overflow_d;
  logic               idle_done;
  logic               timeout_hit;

  // State and datapath registers, all on the falling edge.
  always_ff @(negedge in_clk) begin
    if (in_PoR) begin
      state_q    <= StIdle;
      idle_cnt_q <= '0;
      etu_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      etu_cnt_q  <= etu_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Next state: disable beats SoF, SoF beats everything else in every state.
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    etu_cnt_d   = etu_cnt_q;
    overflow_d  = overflow_q;
    idle_done   = 1'b0;
    timeout_hit = 1'b0;
    if (!in_enable) begin
      idle_cnt_d = '0;
      state_d    = StIdle;
    end else if (in_sof) begin
      idle_cnt_d = '0;
      etu_cnt_d  = '0;
      overflow_d = 1'b0;
      state_d    = StActive;
    end else begin
      case (state_q)
        StActive: begin
          if (!in_data) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == IdleLast) begin
            idle_cnt_d = '0;
            idle_done  = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
          if (in_etu_strobe && (etu_cnt_q != CntMax)) begin
            etu_cnt_d = etu_cnt_q + 1'b1;
          end
          if (etu_cnt_d == CntMax) begin
            overflow_d = 1'b1;
          end
`ifdef EOF_TIMEOUT_EN
          timeout_hit = in_etu_strobe && (32'(etu_cnt_d) == MAX_ETU) && !idle_done;
`endif
          if (idle_done) begin
            state_d = StEof;
          end else if (timeout_hit) begin
            state_d = StIdle;
          end
        end
        StEof:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

`ifdef EOF_TIMEOUT_EN
  logic timeout_q;

  always_ff @(negedge in_clk) begin
    if (in_PoR) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
    end
  end
`else
  logic        timeout_q;
  logic [31:0] unused_max_etu;
  logic        unused_timeout_hit;

  assign timeout_q          = 1'b0;
  assign unused_max_etu     = MAX_ETU;
  assign unused_timeout_hit = timeout_hit;
`endif

  always_comb begin
    out_eof          = (state_q == StEof);
    out_frame_active = (state_q == StActive);
    out_etu_count    = etu_cnt_q;
    out_overflow     = overflow_q;
    out_timeout      = timeout_q;
  end

endmodule

// File: tb/tb_miller_eof_detector.sv
// Directed bench for miller_eof_detector: main instance plus a 4-bit counter instance
// for saturation, both driven from the same stimulus.
module tb_miller_eof_detector;

  logic       in_clk = 1'b0;
  logic       in_PoR, in_enable, in_sof, in_data, in_etu_strobe;
  logic       eof, active, ovf, tmo;
  logic [9:0] cnt;
  logic       s_eof, s_active, s_ovf, s_tmo;
  logic [3:0] s_cnt;

  int checks   = 0;
  int failures = 0;

`ifdef EOF_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  miller_eof_detector #(
    .CLK_PER_ETU(8), .IDLE_ETU(2), .CNT_W(10), .MAX_ETU(12)
  ) dut (
    .in_clk(in_clk), .in_PoR(in_PoR), .in_enable(in_enable), .in_sof(in_sof),
    .in_data(in_data), .in_etu_strobe(in_etu_strobe), .out_eof(eof),
    .out_frame_active(active), .out_etu_count(cnt), .out_overflow(ovf),
    .out_timeout(tmo)
  );

  miller_eof_detector #(
    .CLK_PER_ETU(8), .IDLE_ETU(2), .CNT_W(4), .MAX_ETU(512)
  ) dut_sat (
    .in_clk(in_clk), .in_PoR(in_PoR), .in_enable(in_enable), .in_sof(in_sof),
    .in_data(in_data), .in_etu_strobe(in_etu_strobe), .out_eof(s_eof),
    .out_frame_active(s_active), .out_etu_count(s_cnt), .out_overflow(s_ovf),
    .out_timeout(s_tmo)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change just after a rising edge; the DUT samples on the falling edge and
  // outputs are read at the next rising edge.
  task automatic step(input logic sof, input logic data, input logic strobe);
    in_sof        = sof;
    in_data       = data;
    in_etu_strobe = strobe;
    @(posedge in_clk);
  endtask

  // One ETU: six carrier clocks, two pause clocks, strobe on the last pause clock.
  task automatic etus(input int n);
    for (int e = 0; e < n; e++) begin
      for (int c = 0; c < 8; c++) begin
        step(1'b0, c < 6, c == 7);
        chk("etu_no_eof", eof, 0);
      end
    end
  endtask

  initial begin
    in_PoR = 1'b1; in_enable = 1'b1; in_sof = 1'b0; in_data = 1'b1; in_etu_strobe = 1'b0;
    @(posedge in_clk);

    // Reset state.
    step(1'b0, 1'b1, 1'b0);
    chk("rst_eof", eof, 0);
    chk("rst_active", active, 0);
    chk("rst_count", cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_tmo", tmo, 0);
    in_PoR = 1'b0;

    // Nominal frame: 9 ETUs, then 16 high clocks with strobes on clocks 8 and 16.
    step(1'b1, 1'b1, 1'b0);
    chk("sof_active", active, 1);
    chk("sof_count", cnt, 0);
    etus(9);
    chk("nom_count_9", cnt, 9);
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 1'b1, i == 8);
      chk("nom_idle_no_eof", eof, 0);
      chk("nom_idle_active", active, 1);
    end
    step(1'b0, 1'b1, 1'b1);
    chk("nom_eof", eof, 1);
    chk("nom_eof_active", active, 0);
    chk("nom_eof_count", cnt, 11);
    chk("nom_ovf", ovf, 0);
    step(1'b0, 1'b1, 1'b0);
    chk("nom_eof_pulse_end", eof, 0);
    chk("nom_idle_count_held", cnt, 11);
    chk("nom_idle_active", active, 0);

    // Re-arm 20 clocks after EoF, with a near-miss 15-clock run before the real EoF.
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b1, 1'b1);
      chk("gap_no_eof", eof, 0);
    end
    chk("gap_count_held", cnt, 11);
    step(1'b1, 1'b1, 1'b0);
    chk("rearm_active", active, 1);
    chk("rearm_count", cnt, 0);
    etus(3);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("near_no_eof", eof, 0);
    end
    step(1'b0, 1'b0, 1'b0);
    chk("near_pause_no_eof", eof, 0);
    chk("near_pause_active", active, 1);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("near_run_no_eof", eof, 0);
    end
    step(1'b0, 1'b1, 1'b0);
    chk("rearm_eof", eof, 1);
    chk("rearm_eof_count", cnt, 3);

    // SoF while in EOF: pulse already out, goes straight back to ACTIVE.
    step(1'b1, 1'b1, 1'b0);
    chk("sof_in_eof_pulse_end", eof, 0);
    chk("sof_in_eof_active", active, 1);
    chk("sof_in_eof_count", cnt, 0);

    // SoF on the edge where EoF would fire restarts the frame instead.
    etus(1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("restart_no_eof", eof, 0);
    chk("restart_active", active, 1);
    chk("restart_count", cnt, 0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0);
    chk("restart_15_no_eof", eof, 0);
    step(1'b0, 1'b1, 1'b0);
    chk("restart_eof", eof, 1);

    // Reset mid-frame at ETU 5, then a long idle line must not raise EoF.
    step(1'b1, 1'b1, 1'b0);
    etus(4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    in_PoR = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    in_PoR = 1'b0;
    chk("midrst_eof", eof, 0);
    chk("midrst_active", active, 0);
    chk("midrst_count", cnt, 0);
    chk("midrst_ovf", ovf, 0);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("midrst_idle_no_eof", eof, 0);
      chk("midrst_idle_inactive", active, 0);
    end

    // Disable mid-frame: drop to IDLE, hold count, ignore SoF while disabled.
    step(1'b1, 1'b1, 1'b0);
    etus(2);
    in_enable = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    chk("dis_active", active, 0);
    chk("dis_count_held", cnt, 2);
    step(1'b1, 1'b1, 1'b1);
    chk("dis_sof_ignored", active, 0);
    chk("dis_sof_count", cnt, 2);
    in_enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("dis_no_eof", eof, 0);
    end

    // Saturation on the 4-bit instance.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
    chk("sat_count", s_cnt, 15);
    chk("sat_ovf", s_ovf, 1);
    chk("sat_active", s_active, 1);
    step(1'b1, 1'b0, 1'b0);
    chk("sat_sof_count", s_cnt, 0);
    chk("sat_sof_ovf", s_ovf, 0);

    // Timeout at 12 ETUs on the main instance.
    in_PoR = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    in_PoR = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    for (int e = 0; e < 12; e++) begin
      for (int c = 0; c < 8; c++) begin
        step(1'b0, c < 6, c == 7);
        chk("tmo_pulse", tmo, (TmoEn && e == 11 && c == 7) ? 1 : 0);
        chk("tmo_no_eof", eof, 0);
      end
    end
    chk("tmo_active", active, TmoEn ? 0 : 1);
    chk("tmo_count", cnt, 12);
    step(1'b0, 1'b0, 1'b0);
    chk("tmo_pulse_end", tmo, 0);
    chk("tmo_after_active", active, TmoEn ? 0 : 1);
    chk("tmo_after_no_eof", eof, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
